// File: rtl/dfx_mailbox_regs.sv
// AXI4-Lite mailbox bank: per-channel host control word, MCU status shadow with change flags,
// and doorbells with MCU acknowledge. One write and one read outstanding; 1-cycle response.
module dfx_mailbox_regs #(
    parameter int          NUM_CH     = 4,
    parameter logic [31:0] CTRL_RESET = 32'h0000_0000,
    parameter logic [31:0] BLOCK_ID   = 32'h0DF0_0100
) (
    input  logic                   AxiBusClock,
    input  logic                   xAxiBusReset,
    input  logic [11:0]            xPcieToDfx_AXI_awaddr,
    input  logic [2:0]             xPcieToDfx_AXI_awprot,
    input  logic                   xPcieToDfx_AXI_awvalid,
    output logic                   xPcieToDfx_AXI_awready,
    input  logic [31:0]            xPcieToDfx_AXI_wdata,
    input  logic [3:0]             xPcieToDfx_AXI_wstrb,
    input  logic                   xPcieToDfx_AXI_wvalid,
    output logic                   xPcieToDfx_AXI_wready,
    output logic [1:0]             xPcieToDfx_AXI_bresp,
    output logic                   xPcieToDfx_AXI_bvalid,
    input  logic                   xPcieToDfx_AXI_bready,
    input  logic [11:0]            xPcieToDfx_AXI_araddr,
    input  logic [2:0]             xPcieToDfx_AXI_arprot,
    input  logic                   xPcieToDfx_AXI_arvalid,
    output logic                   xPcieToDfx_AXI_arready,
    output logic [31:0]            xPcieToDfx_AXI_rdata,
    output logic [1:0]             xPcieToDfx_AXI_rresp,
    output logic                   xPcieToDfx_AXI_rvalid,
    input  logic                   xPcieToDfx_AXI_rready,
    output logic [NUM_CH*32-1:0]   xCtrlOut,
    input  logic [NUM_CH*32-1:0]   xStatusIn,
    input  logic [NUM_CH-1:0]      xDoorbellAck,
    output logic [NUM_CH-1:0]      xDoorbellPend,
    output logic                   xMcuIrq,
    output logic                   xHostIrq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [9:0] A_ID   = 10'h000;
    localparam logic [9:0] A_CAPS = 10'h001;
    localparam logic [9:0] A_PEND = 10'h004;
    localparam logic [9:0] A_SET  = 10'h005;
    localparam logic [9:0] A_EN   = 10'h006;
    localparam logic [9:0] A_CHG  = 10'h007;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    // Channel window: word 0 of each 16-byte slot is CTRL, word 1 is STATUS.
    function automatic logic chan_hit(input logic [9:0] wa);
        return (wa[9:6] == 4'h1) && !wa[1] && (int'(wa[5:2]) < NUM_CH);
    endfunction

    w_state_t                  w_state_q, w_state_d;
    r_state_t                  r_state_q, r_state_d;
    logic                      aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [9:0]                awaddr_q, awaddr_d;
    logic [31:0]               wdata_q, wdata_d;
    logic [3:0]                wstrb_q, wstrb_d;
    logic                      awready_q, awready_d, wready_q, wready_d;
    logic                      bvalid_q, bvalid_d, arready_q, arready_d, rvalid_q, rvalid_d;
    logic [1:0]                bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0]               rdata_q, rdata_d;
    logic [NUM_CH-1:0][31:0]   ctrl_q, ctrl_d, shadow_q, status_in;
    logic [NUM_CH-1:0]         pend_q, pend_d, en_q, en_d, chg_q, chg_d;
    logic                      primed_q, mcu_irq_q, mcu_irq_d, host_irq_q, host_irq_d;

    logic                      aw_hs, w_hs, ar_hs, have_aw, have_w, do_write, wr_ok;
    logic [9:0]                wa, ra;
    logic [31:0]               wr_data, wr_mask, rd_data;
    logic [3:0]                wr_strb;
    logic [1:0]                rd_resp;
    logic [NUM_CH-1:0]         db_set, chg_clr, status_diff;
    logic                      unused_ok;

    assign status_in = xStatusIn;
    assign unused_ok = ^{xPcieToDfx_AXI_awaddr[1:0], xPcieToDfx_AXI_araddr[1:0],
                         xPcieToDfx_AXI_awprot, xPcieToDfx_AXI_arprot};

    assign aw_hs   = xPcieToDfx_AXI_awvalid & awready_q;
    assign w_hs    = xPcieToDfx_AXI_wvalid & wready_q;
    assign ar_hs   = xPcieToDfx_AXI_arvalid & arready_q;
    assign have_aw = aw_held_q | aw_hs;
    assign have_w  = w_held_q | w_hs;
    assign wa      = aw_held_q ? awaddr_q : xPcieToDfx_AXI_awaddr[11:2];
    assign wr_data = w_held_q ? wdata_q : xPcieToDfx_AXI_wdata;
    assign wr_strb = w_held_q ? wstrb_q : xPcieToDfx_AXI_wstrb;
    assign wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
    assign ra      = xPcieToDfx_AXI_araddr[11:2];

    always_comb begin
        wr_ok = 1'b0;
        case (wa)
            A_ID, A_CAPS, A_PEND, A_SET, A_EN, A_CHG: wr_ok = 1'b1;
            default:                                 wr_ok = chan_hit(wa);
        endcase
    end

    // Write channel: AW and W are latched independently; the update fires once both are in hand.
    always_comb begin
        w_state_d = w_state_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        do_write  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    awaddr_d  = xPcieToDfx_AXI_awaddr[11:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    wdata_d  = xPcieToDfx_AXI_wdata;
                    wstrb_d  = xPcieToDfx_AXI_wstrb;
                end
                if (have_aw && have_w) begin
                    do_write  = 1'b1;
                    bvalid_d  = 1'b1;
                    bresp_d   = wr_ok ? RESP_OKAY : RESP_SLVERR;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    awready_d = !have_aw;
                    wready_d  = !have_w;
                end
            end
            W_RESP: begin
                if (xPcieToDfx_AXI_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        en_d    = en_q;
        db_set  = '0;
        chg_clr = '0;
        if (do_write) begin
            case (wa)
                A_SET:   db_set  = wr_data[NUM_CH-1:0];
                A_EN:    en_d    = wr_data[NUM_CH-1:0];
                A_CHG:   chg_clr = wr_data[NUM_CH-1:0];
                default: begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        if (chan_hit(wa) && !wa[0] && (wa[5:2] == 4'(n)))
                            ctrl_d[n] = (ctrl_q[n] & ~wr_mask) | (wr_data & wr_mask);
                    end
                end
            endcase
        end
        // Set beats ack, and a fresh change beats W1C.
        for (int n = 0; n < NUM_CH; n++)
            status_diff[n] = primed_q && (status_in[n] != shadow_q[n]);
        pend_d     = (pend_q & ~xDoorbellAck) | db_set;
        chg_d      = (chg_q & ~chg_clr) | status_diff;
        mcu_irq_d  = |(pend_q & en_q);
        host_irq_d = |chg_q;
    end

    always_comb begin
        rd_data = '0;
        rd_resp = RESP_OKAY;
        case (ra)
            A_ID:   rd_data = BLOCK_ID;
            A_CAPS: rd_data = {24'h0, 8'(NUM_CH)};
            A_PEND: rd_data = 32'(pend_q);
            A_SET:  rd_data = '0;
            A_EN:   rd_data = 32'(en_q);
            A_CHG:  rd_data = 32'(chg_q);
            default: begin
                if (chan_hit(ra)) begin
                    for (int n = 0; n < NUM_CH; n++) begin
                        if (ra[5:2] == 4'(n))
                            rd_data = ra[0] ? shadow_q[n] : ctrl_q[n];
                    end
                end else begin
                    rd_resp = RESP_SLVERR;
                end
            end
        endcase
    end

    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                arready_d = 1'b1;
                if (ar_hs) begin
                    rdata_d   = rd_data;
                    rresp_d   = rd_resp;
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (xPcieToDfx_AXI_rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge AxiBusClock) begin
        if (xAxiBusReset) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= '0;
            ctrl_q     <= {NUM_CH{CTRL_RESET}};
            shadow_q   <= '0;
            pend_q     <= '0;
            en_q       <= '0;
            chg_q      <= '0;
            primed_q   <= 1'b0;
            mcu_irq_q  <= 1'b0;
            host_irq_q <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            ctrl_q     <= ctrl_d;
            shadow_q   <= status_in;
            pend_q     <= pend_d;
            en_q       <= en_d;
            chg_q      <= chg_d;
            primed_q   <= 1'b1;
            mcu_irq_q  <= mcu_irq_d;
            host_irq_q <= host_irq_d;
        end
    end

    assign xPcieToDfx_AXI_awready = awready_q;
    assign xPcieToDfx_AXI_wready  = wready_q;
    assign xPcieToDfx_AXI_bvalid  = bvalid_q;
    assign xPcieToDfx_AXI_bresp   = bresp_q;
    assign xPcieToDfx_AXI_arready = arready_q;
    assign xPcieToDfx_AXI_rvalid  = rvalid_q;
    assign xPcieToDfx_AXI_rdata   = rdata_q;
    assign xPcieToDfx_AXI_rresp   = rresp_q;
    assign xCtrlOut               = ctrl_q;
    assign xDoorbellPend          = pend_q;
    assign xMcuIrq                = mcu_irq_q;
    assign xHostIrq               = host_irq_q;

endmodule
